// File: rtl/rand_arbiter_if.sv
// Request/result bundle between the requesters and the shared random-number arbiter.
interface rand_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE_BITS = 11
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*SIZE_BITS-1:0] req_max;
  logic                         stir;
  logic [NUM_REQ-1:0]           ack;
  logic [SIZE_BITS-1:0]         dout;
  logic                         busy;

  modport master (output req, req_max, stir, input ack, dout, busy);
  modport slave  (input req, req_max, stir, output ack, dout, busy);
endinterface

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR among requesters; each grant
// returns the LFSR sample reduced into [0, req_max] by a serial restoring remainder.
module rand_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SIZE_BITS = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           resetN,
  rand_arbiter_if.slave  bus
);
  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned MW = SIZE_BITS + 1;
  localparam int unsigned BW = (SIZE_BITS > 1) ? $clog2(SIZE_BITS) : 1;
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  typedef enum logic {IDLE, CALC} state_t;

  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [15:0]          r_cyc_cnt;
  logic                 r_stir_d;
  logic [GW-1:0]        r_last_grant;
  logic [GW-1:0]        r_gnt;
  logic [SIZE_BITS-1:0] r_sample;
  logic [MW-1:0]        r_modv;
  logic [MW-1:0]        r_rem;
  logic [BW-1:0]        r_bitidx;
  logic [NUM_REQ-1:0]   r_ack;
  logic [SIZE_BITS-1:0] r_dout;
  logic                 r_busy;

  logic [15:0]          w_lfsr_step;
  logic [15:0]          w_lfsr_mix;
  logic [15:0]          w_lfsr_next;
  logic                 w_stir_rise;
  logic [GW-1:0]        w_idx;
  logic [GW-1:0]        w_win;
  logic [SIZE_BITS-1:0] w_max;
  logic [MW:0]          w_t;
  logic [MW-1:0]        w_rem_next;

  // Galois step; a stir rising edge folds in the cycle counter, never leaving zero.
  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
  assign w_stir_rise = bus.stir & ~r_stir_d;
  assign w_lfsr_mix  = w_lfsr_step ^ r_cyc_cnt;
  assign w_lfsr_next = !w_stir_rise            ? w_lfsr_step :
                       (w_lfsr_mix == 16'h0000) ? 16'h0001    : w_lfsr_mix;

  // Scan in reverse so the first set bit after last_grant is the one that sticks.
  always_comb begin
    w_win = r_last_grant;
    w_idx = r_last_grant;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
      if (bus.req[w_idx]) w_win = w_idx;
    end
  end

  assign w_max      = bus.req_max[w_win*SIZE_BITS +: SIZE_BITS];
  assign w_t        = {r_rem, r_sample[r_bitidx]};
  assign w_rem_next = (w_t >= {1'b0, r_modv}) ? MW'(w_t - {1'b0, r_modv}) : MW'(w_t);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_lfsr       <= SEED_EFF;
      r_cyc_cnt    <= '0;
      r_stir_d     <= 1'b0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_gnt        <= '0;
      r_sample     <= '0;
      r_modv       <= '0;
      r_rem        <= '0;
      r_bitidx     <= '0;
      r_ack        <= '0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_lfsr    <= w_lfsr_next;
      r_cyc_cnt <= r_cyc_cnt + 16'd1;
      r_stir_d  <= bus.stir;
      r_ack     <= '0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (|bus.req) begin
            r_sample     <= r_lfsr[SIZE_BITS-1:0];
            r_modv       <= {1'b0, w_max} + MW'(1);
            r_gnt        <= w_win;
            r_last_grant <= w_win;
            r_rem        <= '0;
            r_bitidx     <= BW'(SIZE_BITS - 1);
            r_busy       <= 1'b1;
            r_state      <= CALC;
          end
        end
        CALC: begin
          r_rem    <= w_rem_next;
          r_bitidx <= r_bitidx - BW'(1);
          if (r_bitidx == '0) begin
            r_dout  <= w_rem_next[SIZE_BITS-1:0];
            r_ack   <= NUM_REQ'(1) << r_gnt;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack  = r_ack;
  assign bus.dout = r_dout;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: a reference model queues expected results at
// each grant and the negedge monitor pops and compares them when ack fires.
module tb_rand_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned SB = 11;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  rand_arbiter_if #(.NUM_REQ(NR), .SIZE_BITS(SB)) ifc ();
  rand_arbiter_if #(.NUM_REQ(NR), .SIZE_BITS(SB)) ifz ();

  rand_arbiter #(.NUM_REQ(NR), .SIZE_BITS(SB), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetN(resetN), .bus(ifc));
  // Seed 4 steps to 2 then 1; stirring with cyc_cnt=1 on the second edge yields zero.
  rand_arbiter #(.NUM_REQ(NR), .SIZE_BITS(SB), .LFSR_SEED(16'h0004)) dut_z (
    .clk(clk), .resetN(resetN), .bus(ifz));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int rr_winner(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct { int gnt; logic [SB-1:0] val; } exp_t;
  exp_t sb[$];

  logic [15:0]    m_lfsr, m_cyc;
  logic           m_stir_d, m_busy;
  int             m_cnt, m_last, m_gnt;
  logic [NR-1:0]  m_ack;
  logic [SB-1:0]  last_val;

  // Reference model: behavioural LFSR, round-robin pick and plain modulo.
  always @(posedge clk) begin
    logic [15:0] nx;
    int g, mx;
    exp_t e;
    if (!resetN) begin
      m_lfsr <= 16'hACE1; m_cyc <= '0; m_stir_d <= 1'b0; m_busy <= 1'b0;
      m_cnt <= 0; m_last <= NR - 1; m_gnt <= 0; m_ack <= '0;
      sb.delete();
    end else begin
      nx = lfsr_step(m_lfsr);
      if (ifc.stir && !m_stir_d) begin
        nx = nx ^ m_cyc;
        if (nx == 16'h0000) nx = 16'h0001;
      end
      m_lfsr   <= nx;
      m_cyc    <= m_cyc + 16'd1;
      m_stir_d <= ifc.stir;
      m_ack    <= '0;
      if (!m_busy) begin
        if (ifc.req != '0) begin
          g  = rr_winner(ifc.req, m_last);
          mx = int'(ifc.req_max[g*SB +: SB]) + 1;
          e.gnt = g;
          e.val = SB'(int'(m_lfsr[SB-1:0]) % mx);
          sb.push_back(e);
          m_last <= g; m_gnt <= g; m_busy <= 1'b1; m_cnt <= SB;
        end
      end else begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_ack  <= NR'(1) << m_gnt;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor: any ack activity on either side is compared; expected acks pop the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetN === 1'b1 && ((ifc.ack | m_ack) != '0)) begin
      check("ack_vec", 32'(ifc.ack), 32'(m_ack));
      if (m_ack != '0) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("dout", 32'(ifc.dout), 32'(e.val));
          check("ack_gnt", 32'(ifc.ack), 32'(1) << e.gnt);
          check("busy_at_ack", 32'(ifc.busy), 32'(0));
          last_val = e.val;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
  endtask

  task automatic wait_any(input int budget, output int cyc, output logic [NR-1:0] a);
    cyc = 0;
    a   = '0;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (ifc.ack != '0) begin
        cyc = i;
        a   = ifc.ack;
        break;
      end
    end
    check("ack_seen", 32'(a != '0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, seen, mx;
    logic [NR-1:0] a;
    logic [15:0] ex;

    resetN = 1'b0;
    ifc.req = '0; ifc.req_max = '0; ifc.stir = 1'b0;
    ifz.req = '0; ifz.req_max = '0; ifz.stir = 1'b0;
    tick(2);
    check("rst_ack", 32'(ifc.ack), 32'(0));
    check("rst_dout", 32'(ifc.dout), 32'(0));
    check("rst_busy", 32'(ifc.busy), 32'(0));
    check("rst_lfsr", 32'(dut.r_lfsr), 32'(16'hACE1));
    resetN = 1'b1;

    // Stir result of zero is replaced by 1.
    tick(1);
    check("zseed_step", 32'(dut_z.r_lfsr), 32'(16'h0002));
    ifz.stir = 1'b1;
    tick(1);
    check("stir_zero_fix", 32'(dut_z.r_lfsr), 32'(16'h0001));
    ifz.stir = 1'b0;

    // Full-range request: latency and unchanged sample.
    ifc.req_max[SB-1:0] = 11'd2047;
    ifc.req = 4'b0001;
    wait_any(20, cyc, a);
    ifc.req = '0;
    check("latency", 32'(cyc), 32'(12));
    check("ack0", 32'(a), 32'(1));
    tick(3);
    check("dout_hold", 32'(ifc.dout), 32'(last_val));
    check("busy_idle", 32'(ifc.busy), 32'(0));

    // Small ranges, back-to-back, with stir wiggling mid-transaction.
    for (int i = 0; i < 200; i++) begin
      mx = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 6;
      ifc.req_max[SB-1:0] = SB'(mx);
      ifc.stir = i[1];
      ifc.req  = 4'b0001;
      wait_any(20, cyc, a);
      ifc.req = '0;
      check("range", 32'(ifc.dout <= SB'(mx)), 32'(1));
    end
    ifc.stir = 1'b0;

    // All requesting: strict rotation, 12-cycle spacing.
    ifc.req_max = {11'd100, 11'd7, 11'd2047, 11'd3};
    do_reset();
    ifc.req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_any(20, cyc, a);
      check("rr_order", 32'(a), 32'(1) << (n % 4));
      check("rr_spacing", 32'(cyc), 32'(12));
      check("rr_onehot", 32'($countones(a)), 32'(1));
    end
    ifc.req = '0;
    tick(2);

    // One-cycle pulse on req[2] while busy is not remembered.
    ifc.req = 4'b0001;
    tick(1);
    ifc.req = 4'b0110;
    tick(1);
    ifc.req = 4'b0010;
    wait_any(20, cyc, a);
    check("pulse_first", 32'(a), 32'(4'b0001));
    wait_any(20, cyc, a);
    ifc.req = '0;
    check("pulse_next", 32'(a), 32'(4'b0010));
    seen = 0;
    repeat (30) begin
      tick(1);
      if (ifc.ack != '0) seen++;
    end
    check("no_late_ack", 32'(seen), 32'(0));

    // Stir in IDLE: single perturbation on the rising edge only.
    check("mdl_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
    ex = lfsr_step(m_lfsr) ^ m_cyc;
    if (ex == 16'h0000) ex = 16'h0001;
    ifc.stir = 1'b1;
    tick(1);
    check("stir_mix", 32'(dut.r_lfsr), 32'(ex));
    ex = lfsr_step(ex);
    tick(1);
    check("stir_held1", 32'(dut.r_lfsr), 32'(ex));
    ex = lfsr_step(ex);
    tick(1);
    check("stir_held2", 32'(dut.r_lfsr), 32'(ex));
    ifc.stir = 1'b0;
    tick(2);

    // Reset mid-reduction aborts with no ack; requester 0 regains first priority.
    ifc.req = 4'b0010;
    tick(1);
    ifc.req = '0;
    tick(4);
    ifc.req = 4'b1111;
    resetN  = 1'b0;
    tick(1);
    check("midrst_ack", 32'(ifc.ack), 32'(0));
    check("midrst_busy", 32'(ifc.busy), 32'(0));
    check("midrst_dout", 32'(ifc.dout), 32'(0));
    check("midrst_lfsr", 32'(dut.r_lfsr), 32'(16'hACE1));
    resetN = 1'b1;
    wait_any(20, cyc, a);
    ifc.req = '0;
    check("postrst_first", 32'(a), 32'(4'b0001));
    check("postrst_lat", 32'(cyc), 32'(12));
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
